// File: rtl/buzzer_tone_ctrl.sv
// buzzer_tone_ctrl: Avalon-MM buzzer with direct level, square-wave tone and beep cadence sequencer.
// Optional BUZZER_TONE_IRQ_EN adds irq output and IRQ_EN register at address 6.
module buzzer_tone_ctrl #(
    parameter int DIV_W = 16,
    parameter int DUR_W = 24,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
`ifdef BUZZER_TONE_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ON = 2'd1, S_OFF = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             direct_q, direct_d, done_q, done_d, tone_q, tone_d;
    logic             out_q, out_d, busy_q, busy_d;
    logic [DIV_W-1:0] half_q, half_d, sh_half_q, sh_half_d, div_q, div_d;
    logic [DUR_W-1:0] on_q, on_d, off_q, off_d, sh_on_q, sh_on_d, sh_off_q, sh_off_d, dur_q, dur_d;
    logic [CNT_W-1:0] rep_q, rep_d, rem_q, rem_d;
    logic             wr, cmd, start, stop, clr;
    logic             unused_wdata;
`ifdef BUZZER_TONE_IRQ_EN
    logic             irq_en_q, irq_en_d, irq_q, irq_d;
`endif

    assign unused_wdata = ^writedata[31:DUR_W];
    assign wr    = chipselect & ~write_n;
    assign cmd   = wr && address == 3'd5;
    assign start = cmd & writedata[0] & ~writedata[1];
    assign stop  = cmd & writedata[1];
    assign clr   = cmd & writedata[2];

    always_comb begin
        state_d   = state_q;
        direct_d  = direct_q;
        half_d    = half_q;
        on_d      = on_q;
        off_d     = off_q;
        rep_d     = rep_q;
        sh_half_d = sh_half_q;
        sh_on_d   = sh_on_q;
        sh_off_d  = sh_off_q;
        rem_d     = rem_q;
        dur_d     = dur_q;
        div_d     = div_q;
        tone_d    = tone_q;
        done_d    = clr ? 1'b0 : done_q;
`ifdef BUZZER_TONE_IRQ_EN
        irq_en_d  = (wr && address == 3'd6) ? writedata[0] : irq_en_q;
`endif
        if (wr) begin
            case (address)
                3'd0:    direct_d = writedata[0];
                3'd1:    half_d   = writedata[DIV_W-1:0];
                3'd2:    on_d     = writedata[DUR_W-1:0];
                3'd3:    off_d    = writedata[DUR_W-1:0];
                3'd4:    rep_d    = writedata[CNT_W-1:0];
                default: ;
            endcase
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_half_d = half_q;
                    sh_on_d   = on_q;
                    sh_off_d  = off_q;
                    rem_d     = rep_q;
                    dur_d     = '0;
                    div_d     = '0;
                    tone_d    = 1'b1;
                    if (rep_q == '0 || on_q == '0) done_d = 1'b1;
                    else state_d = S_ON;
                end
            end
            S_ON: begin
                if (stop) state_d = S_IDLE;
                else if (dur_q == sh_on_q - DUR_W'(1)) begin
                    // Beep finished: restart divider/tone for whichever ON phase comes next
                    rem_d  = rem_q - CNT_W'(1);
                    dur_d  = '0;
                    div_d  = '0;
                    tone_d = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else state_d = (sh_off_q == '0) ? S_ON : S_OFF;
                end else begin
                    dur_d  = dur_q + DUR_W'(1);
                    div_d  = (div_q == sh_half_q) ? '0 : div_q + DIV_W'(1);
                    tone_d = (div_q == sh_half_q) ? ~tone_q : tone_q;
                end
            end
            S_OFF: begin
                if (stop) state_d = S_IDLE;
                else if (dur_q == sh_off_q - DUR_W'(1)) begin
                    state_d = S_ON;
                    dur_d   = '0;
                    div_d   = '0;
                    tone_d  = 1'b1;
                end else dur_d = dur_q + DUR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        out_d  = (state_d == S_ON) ? tone_d : (state_d == S_OFF) ? 1'b0 : direct_q;
        busy_d = state_d != S_IDLE;
`ifdef BUZZER_TONE_IRQ_EN
        irq_d  = done_d & irq_en_d;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            direct_q  <= 1'b0;
            half_q    <= '0;
            on_q      <= '0;
            off_q     <= '0;
            rep_q     <= '0;
            sh_half_q <= '0;
            sh_on_q   <= '0;
            sh_off_q  <= '0;
            rem_q     <= '0;
            dur_q     <= '0;
            div_q     <= '0;
            tone_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef BUZZER_TONE_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            direct_q  <= direct_d;
            half_q    <= half_d;
            on_q      <= on_d;
            off_q     <= off_d;
            rep_q     <= rep_d;
            sh_half_q <= sh_half_d;
            sh_on_q   <= sh_on_d;
            sh_off_q  <= sh_off_d;
            rem_q     <= rem_d;
            dur_q     <= dur_d;
            div_q     <= div_d;
            tone_q    <= tone_d;
            done_q    <= done_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
`ifdef BUZZER_TONE_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    always_comb begin
        case (address)
            3'd0:    readdata = {31'd0, direct_q};
            3'd1:    readdata = 32'(half_q);
            3'd2:    readdata = 32'(on_q);
            3'd3:    readdata = 32'(off_q);
            3'd4:    readdata = 32'(rep_q);
            3'd5:    readdata = {30'd0, done_q, busy_q};
`ifdef BUZZER_TONE_IRQ_EN
            3'd6:    readdata = {31'd0, irq_en_q};
`endif
            default: readdata = 32'd0;
        endcase
    end

    assign out_port = out_q;
    assign busy     = busy_q;
`ifdef BUZZER_TONE_IRQ_EN
    assign irq      = irq_q;
`endif
endmodule

// File: tb/tb_buzzer_tone_ctrl.sv
// tb_buzzer_tone_ctrl: directed bench for buzzer_tone_ctrl (register table plus cadence sequences).
module tb_buzzer_tone_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        out_port, busy;
`ifdef BUZZER_TONE_IRQ_EN
    logic        irq;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs[8];

    // ON=8 HALF=1 OFF=4 REPEAT=2 cadence, first ON cycle first (MSB)
    localparam logic [19:0] PAT = 20'b11001100_0000_11001100;

    buzzer_tone_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port),
`ifdef BUZZER_TONE_IRQ_EN
        .irq(irq),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called at a negedge; write is captured at the next posedge, returns at the following negedge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h1};
        vecs[1] = '{3'd1, 32'h1234_5678, 32'h5678};
        vecs[2] = '{3'd2, 32'hABCD_EF12, 32'hCD_EF12};
        vecs[3] = '{3'd3, 32'h0100_0003, 32'h3};
        vecs[4] = '{3'd4, 32'h0000_01FF, 32'hFF};
`ifdef BUZZER_TONE_IRQ_EN
        vecs[5] = '{3'd6, 32'h0000_0001, 32'h1};
`else
        vecs[5] = '{3'd6, 32'h0000_0001, 32'h0};
`endif
        vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{3'd5, 32'h0000_0000, 32'h0};

        // T1 reset
        #1;
        chk("rst_out", 32'(out_port), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), 3'(i), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].a, vecs[i].wd);
            rd_chk($sformatf("reg%0d", vecs[i].a), vecs[i].a, vecs[i].rd);
        end
        @(negedge clk);
        chk("tbl_direct_out", 32'(out_port), 1);

        // T2 direct level latency
        wr(0, 0);
        chk("t2_lat_old", 32'(out_port), 1);
        @(negedge clk);
        chk("t2_off", 32'(out_port), 0);
        wr(0, 1);
        chk("t2_lat_old1", 32'(out_port), 0);
        @(negedge clk);
        chk("t2_on", 32'(out_port), 1);
        rd_chk("t2_rd", 0, 1);
        wr(0, 0);
        @(negedge clk);

        // T3 full cadence
        wr(1, 1); wr(2, 8); wr(3, 4); wr(4, 2);
        wr(5, 1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t3_out%0d", i), 32'(out_port), 32'(PAT[19-i]));
            chk($sformatf("t3_busy%0d", i), 32'(busy), 1);
            @(negedge clk);
        end
        chk("t3_end_busy", 32'(busy), 0);
        chk("t3_end_out", 32'(out_port), 0);
        rd_chk("t3_done", 5, 2);
`ifdef BUZZER_TONE_IRQ_EN
        chk("t6_irq", 32'(irq), 1);
        wr(5, 4);
        chk("t6_irq_clr", 32'(irq), 0);
`endif

        // T4 stop mid-beep, DIRECT written while busy
        wr(5, 4);
        rd_chk("t4_clr", 5, 0);
        wr(5, 1);
        chk("t4_c0", 32'(out_port), 1);
        chk("t4_busy", 32'(busy), 1);
        @(negedge clk);
        wr(0, 1);
        chk("t4_direct_hidden", 32'(out_port), 0);
        wr(5, 2);
        chk("t4_stop_out", 32'(out_port), 1);
        chk("t4_stop_busy", 32'(busy), 0);
        rd_chk("t4_stop_done", 5, 0);
        wr(0, 0);
        @(negedge clk);
        chk("t4_direct0", 32'(out_port), 0);

        // T4b START while busy ignored
        wr(5, 1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4b_out%0d", i), 32'(out_port), 32'(PAT[19-i]));
            chk($sformatf("t4b_busy%0d", i), 32'(busy), 1);
            if (i == 1) wr(5, 1);
            else @(negedge clk);
        end
        chk("t4b_end_busy", 32'(busy), 0);
        rd_chk("t4b_done", 5, 2);

        // OFF_TIME=0: back-to-back beeps, HALF=0 gives clk/2
        wr(5, 4); wr(1, 0); wr(2, 2); wr(3, 0); wr(4, 2);
        wr(5, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("off0_out%0d", i), 32'(out_port), 32'((i + 1) % 2));
            chk($sformatf("off0_busy%0d", i), 32'(busy), 1);
            @(negedge clk);
        end
        chk("off0_end", 32'(busy), 0);

        // ON_TIME=0 finishes immediately
        wr(2, 0); wr(5, 4);
        wr(5, 1);
        chk("on0_busy", 32'(busy), 0);
        rd_chk("on0_done", 5, 2);

        // T5 REPEAT=0, CLR_DONE, START+STOP
        wr(5, 4); wr(2, 8); wr(4, 0);
        wr(5, 1);
        chk("t5_busy", 32'(busy), 0);
        rd_chk("t5_done", 5, 2);
        wr(5, 4);
        rd_chk("t5_clr", 5, 0);
        wr(4, 2);
        wr(5, 3);
        chk("t5_ss_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t5_ss_busy2", 32'(busy), 0);
        rd_chk("t5_ss_done", 5, 0);

        // Async reset mid-sequence
        wr(1, 1); wr(3, 4);
        wr(5, 1);
        @(negedge clk);
        chk("ar_pre_busy", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_out", 32'(out_port), 0);
        chk("ar_busy", 32'(busy), 0);
        for (int i = 1; i < 6; i++) rd_chk($sformatf("ar_rd%0d", i), 3'(i), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
